// File: rtl/seq_gen.sv
// -----------------------------------------------------------------------------
// seq_gen
// Serial test-pattern transmitter for the sequence detector FSMs. On an
// accepted start it latches a WIDTH-bit pattern and a repeat count. It then
// shifts the pattern out MSB first, one bit per clock, for repeat_n back-to-back
// repetitions, and finishes with a one-cycle done pulse.
//
// Optional feature:
//   SEQ_GEN_GAP_EN  when defined, one idle cycle (out_valid=0, out=0, busy=1)
//                   is inserted between consecutive repetitions.
//
// Parameters:
//   WIDTH      pattern length in bits (>= 2)
//   CNT_W      width of the repeat count
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   start      transmit request, only honoured in IDLE
//   abort      synchronous cancel while transmitting; no done pulse
//   pattern    bit pattern, latched on an accepted start
//   repeat_n   number of repetitions, latched on an accepted start
//   out        serial bit for the detector input
//   out_valid  out carries a pattern bit this cycle
//   busy       transmission in progress
//   done       one-cycle completion pulse
// -----------------------------------------------------------------------------
module seq_gen #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
`ifdef SEQ_GEN_GAP_EN
    , GAP = 2'd3
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shift_reg, shift_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic             out_n, valid_n, busy_n, done_n;

  // State, datapath and output registers. The outputs are registered copies of
  // what the next state will present, so nothing reaches an output port
  // combinationally from an input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rep_cnt   <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      rep_cnt   <= rep_n;
      out       <= out_n;
      out_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n = state;
    shift_n = shift_reg;
    bit_n   = bit_cnt;
    rep_n   = rep_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          shift_n = pattern;
          rep_n   = repeat_n;
          bit_n   = LAST_BIT;
          state_n = (repeat_n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_n = IDLE;
        end else begin
          // Rotating (not shifting) leaves the original pattern in the
          // register at every repetition boundary, so no reload is needed.
          shift_n = {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]};
          if (bit_cnt == '0) begin
            rep_n = rep_cnt - CNT_W'(1);
            if (rep_cnt == CNT_W'(1)) begin
              state_n = DONE;
            end else begin
              bit_n = LAST_BIT;
`ifdef SEQ_GEN_GAP_EN
              state_n = GAP;
`else
              state_n = SHIFT;
`endif
            end
          end else begin
            bit_n = bit_cnt - BW'(1);
          end
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        state_n = abort ? IDLE : SHIFT;
      end
`endif
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    out_n   = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    if (state_n == SHIFT) begin
      out_n   = shift_n[WIDTH-1];
      valid_n = 1'b1;
      busy_n  = 1'b1;
    end
`ifdef SEQ_GEN_GAP_EN
    if (state_n == GAP) begin
      busy_n = 1'b1;
    end
`endif
    if (state_n == DONE) begin
      done_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_seq_gen
// Self-checking bench for seq_gen. A cycle-level reference model expands every
// accepted start into the list of output tuples {out, out_valid, busy, done}
// the transmitter must produce. The DUT is compared against that list on every
// falling edge. Directed scenarios also pin bit streams, counts and offsets to
// hand-computed constants. Honours SEQ_GEN_GAP_EN in the same way as the RTL.
// -----------------------------------------------------------------------------
module tb_seq_gen;

  localparam int W  = 8;
  localparam int CW = 4;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic [W-1:0]  pattern;
  logic [CW-1:0] repeat_n;
  logic          out;
  logic          out_valid;
  logic          busy;
  logic          done;

  seq_gen #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done)
  );

  // Clock generation, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state: expected tuple for the current cycle plus the
  // tuples still to come. Bit order is {out, out_valid, busy, done}.
  logic [3:0] cur = 4'b0000;
  logic [3:0] expq[$];
  int         cyc       = 0;
  int         acceptCyc = 0;

  // Statistics gathered from the DUT for the directed literal checks.
  int          validCnt, busyCnt, doneCnt, gapCnt, doneOff;
  int          detCnt, detFirst, detLast;
  logic [63:0] bits;
  logic [3:0]  hist;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic clearStats();
    validCnt = 0; busyCnt = 0; doneCnt = 0; gapCnt = 0; doneOff = -1;
    detCnt = 0; detFirst = -1; detLast = -1;
    bits = '0; hist = '0;
  endtask

  // Drives one start request with the given pattern and count, holds it for a
  // single edge, then scrambles the data inputs to show they are not re-read.
  task automatic applyStimulus(input logic [W-1:0] pat, input logic [CW-1:0] n);
    pattern  = pat;
    repeat_n = n;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    pattern  = W'($urandom);
    repeat_n = CW'($urandom);
  endtask

  // Waits (bounded) until the model reports the transmitter idle.
  task automatic waitIdle(input int budget);
    bit reached = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cur == 4'b0000 && expq.size() == 0) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) checkOutput("idle_timeout", 64'd0, 64'd1);
  endtask

  // Behavioural model: on each rising edge advance one cycle. An accepted
  // start expands into every future output tuple at once.
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        expq.delete();
        cur = 4'b0000;
      end else begin
        cyc++;
        if (cur[1] && abort) begin
          expq.delete();
          cur = 4'b0000;
        end else if (expq.size() != 0) begin
          cur = expq.pop_front();
        end else if (cur == 4'b0000 && start) begin
          for (int r = 0; r < int'(repeat_n); r++) begin
            if (GAP_ON && r > 0) expq.push_back(4'b0010);
            for (int i = 0; i < W; i++)
              expq.push_back({pattern[W-1-i], 1'b1, 1'b1, 1'b0});
          end
          expq.push_back(4'b0001);
          acceptCyc = cyc;
          cur = expq.pop_front();
        end else begin
          cur = 4'b0000;
        end
      end
    end
  end

  // Compare process: every cycle the DUT outputs must equal the model tuple.
  // A "0101" overlapping detector also samples out here; the bit of cycle c
  // would be captured by a detector at edge c+1.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cycle_outputs", {60'd0, out, out_valid, busy, done}, {60'd0, cur});
      if (out_valid) begin
        bits = {bits[62:0], out};
        validCnt++;
        hist = {hist[2:0], out};
        if (validCnt >= 4 && hist == 4'b0101) begin
          detCnt++;
          if (detCnt == 1) detFirst = cyc + 1 - acceptCyc;
          detLast = cyc + 1 - acceptCyc;
        end
      end
      if (busy) busyCnt++;
      if (busy && !out_valid) gapCnt++;
      if (done) begin
        doneCnt++;
        doneOff = cyc - acceptCyc;
      end
    end
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    clearStats();
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Idle after reset release.
    repeat (5) @(negedge clk);
    checkOutput("idle_busy_cycles", 64'(busyCnt + doneCnt + validCnt), 64'd0);

    // Single repetition of 10101101.
    clearStats();
    applyStimulus(8'b10101101, 4'd1);
    waitIdle(100);
    checkOutput("rep1_bits", bits, 64'hAD);
    checkOutput("rep1_valid", 64'(validCnt), 64'd8);
    checkOutput("rep1_busy", 64'(busyCnt), 64'd8);
    checkOutput("rep1_done", 64'(doneCnt), 64'd1);
    checkOutput("rep1_done_off", 64'(doneOff), 64'd8);

    // Three repetitions, optionally with gaps.
    clearStats();
    applyStimulus(8'b10101101, 4'd3);
    waitIdle(100);
    checkOutput("rep3_bits", bits, 64'hADADAD);
    checkOutput("rep3_valid", 64'(validCnt), 64'd24);
    checkOutput("rep3_busy", 64'(busyCnt), GAP_ON ? 64'd26 : 64'd24);
    checkOutput("rep3_gaps", 64'(gapCnt), GAP_ON ? 64'd2 : 64'd0);
    checkOutput("rep3_done_off", 64'(doneOff), GAP_ON ? 64'd26 : 64'd24);

    // Zero repetitions: done right after the start edge, no bits.
    clearStats();
    applyStimulus(8'hFF, 4'd0);
    waitIdle(20);
    checkOutput("rep0_valid", 64'(validCnt), 64'd0);
    checkOutput("rep0_done", 64'(doneCnt), 64'd1);
    checkOutput("rep0_done_off", 64'(doneOff), 64'd0);

    // Abort during bit 5 of 0xF0.
    clearStats();
    applyStimulus(8'hF0, 4'd2);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy_now", {63'd0, busy}, 64'd0);
    waitIdle(20);
    checkOutput("abort_valid", 64'(validCnt), 64'd6);
    checkOutput("abort_bits", bits, 64'b111100);
    checkOutput("abort_done", 64'(doneCnt), 64'd0);

    // Restart after two cycles, with an ignored start mid-transmission.
    @(negedge clk);
    clearStats();
    applyStimulus(8'b10101101, 4'd1);
    repeat (3) @(negedge clk);
    pattern  = 8'hFF;
    repeat_n = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitIdle(100);
    checkOutput("restart_bits", bits, 64'hAD);
    checkOutput("restart_valid", 64'(validCnt), 64'd8);
    checkOutput("restart_done", 64'(doneCnt), 64'd1);

    // Asynchronous reset mid-SHIFT.
    applyStimulus(8'b10101101, 4'd3);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset_outputs", {60'd0, out, out_valid, busy, done}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Detector alignment for "0101" on 01010101.
    clearStats();
    applyStimulus(8'b01010101, 4'd1);
    waitIdle(100);
    checkOutput("det_count", 64'(detCnt), 64'd3);
    checkOutput("det_first_edge", 64'(detFirst), 64'd4);
    checkOutput("det_last_edge", 64'(detLast), 64'd8);
    checkOutput("det_done", 64'(doneCnt), 64'd1);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 5) == 0);
      abort    = ($urandom_range(0, 40) == 0);
      pattern  = W'($urandom);
      repeat_n = ($urandom_range(0, 9) == 0) ? CW'($urandom) : CW'($urandom_range(0, 3));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    waitIdle(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial test-pattern transmitter that drives the single-bit input of the sequence detector FSMs in the sequence_detector homework. It latches a WIDTH-bit pattern and a repeat count on a start request. It then shifts the pattern out MSB first, one bit per clock, for the requested number of repetitions, and pulses done when finished. This replaces hand-written `in = ...` stimulus lists with a reusable, synthesizable source, so benches and board demos feed detectors identically.

## Interface
- WIDTH, 8, pattern length in bits (≥2)
- CNT_W, 4, width of the repeat count
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  transmit request, sampled only in IDLE
- abort  input  1  synchronous cancel, returns to IDLE without done
- pattern  input  WIDTH  bit pattern, latched on accepted start
- repeat_n  input  CNT_W  number of back-to-back pattern repetitions, latched on accepted start
- out  output  1  serial bit to detector `in`
- out_valid  output  1  out carries a pattern bit this cycle
- busy  output  1  transmission in progress
- done  output  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, GAP (only with SEQ_GEN_GAP_EN), DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE; out=0, out_valid=0, busy=0, done=0.
  - Shift register, bit counter and repeat counter are cleared.
- IDLE:
  - start=1 latches pattern into the shift register and repeat_n into the repeat counter.
  - If repeat_n≠0: go to SHIFT, with the bit counter set to WIDTH-1.
  - If repeat_n=0: go to DONE. No bits are emitted.
- SHIFT:
  - out=shift_reg[WIDTH-1], out_valid=1, busy=1.
  - Each clock, the register rotates left by one and the bit counter decrements.
  - When the bit counter reaches 0 on the last bit of a repetition, the repeat counter decrements.
  - If the repeat counter was 1: go to DONE.
  - Otherwise: go to SHIFT again (or GAP) with the bit counter reloaded to WIDTH-1.
  - Because the register rotates, it holds the original pattern again at each repetition boundary.
- GAP: out=0, out_valid=0, busy=1 for exactly one cycle, then go to SHIFT.
- DONE: done=1, busy=0, out=0, out_valid=0 for one cycle, then go to IDLE. start is ignored in DONE.
- out=0 whenever out_valid=0.
- Boundary rules:
  - start while busy or in DONE is ignored. pattern and repeat_n changes while busy have no effect.
  - abort=1 in SHIFT or GAP: next state is IDLE, outputs go low, done is not pulsed.
  - abort has priority over the last-bit transition to DONE.
  - abort in IDLE or DONE is ignored.
  - start=1 and abort=1 together in IDLE: start wins.
  - Maximum repeat_n is 2^CNT_W-1. There is no wrap-around; the count decrements only to the final 1.
  - Reset mid-transmission aborts immediately and asynchronously. No done pulse.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Start accepted at rising edge k:
  - The first bit, pattern[WIDTH-1], is valid from edge k to edge k+1.
  - Bit i of repetition r (both 0-based, MSB=bit 0) is valid in cycle k + r·WIDTH + i.
  - With GAP enabled, add r to that cycle index.
- Total valid cycles = WIDTH·repeat_n.
- done is high in the cycle immediately after the last valid bit, i.e. the cycle after edge k+WIDTH·repeat_n without GAP.
- For repeat_n=0, done is high in the cycle after edge k.
- Earliest next accepted start is the edge that ends the done cycle. busy is low in that cycle.
- Detector alignment: the FSM samples out on the same edges, so bit i is sampled at edge k+1+i.

## Configuration
- SEQ_GEN_GAP_EN defined:
  - The GAP state exists.
  - One idle cycle (out_valid=0, out=0) is inserted between consecutive repetitions.
  - There is no gap before the first repetition or after the last.
- Undefined:
  - GAP logic is not compiled.
  - Repetitions are strictly back-to-back.

## Test plan
- Reset release, start=0 for 5 cycles -> out=0, out_valid=0, busy=0, done=0 throughout.
- WIDTH=8, pattern=8'b10101101, repeat_n=1 -> out=1,0,1,0,1,1,0,1 on 8 consecutive valid cycles; done pulses once in the 9th cycle; busy=1 for 8 cycles.
- Same pattern, repeat_n=3, no gap -> 24 contiguous valid bits, pattern repeated exactly 3 times; with SEQ_GEN_GAP_EN, 26 busy cycles with out_valid=0 at cycles 8 and 17.
- repeat_n=0 with start -> no out_valid; done=1 exactly one cycle after the start edge.
- Start on 8'hF0, repeat_n=2, abort asserted at bit 5 -> out_valid low from the next cycle, no done pulse, IDLE. A new start two cycles later transmits normally. A start pulsed mid-transmission is ignored.
- reset driven low asynchronously mid-SHIFT -> all outputs 0 before the next edge. After release and start with 8'b01010101, repeat_n=1, a detector for "0101" connected to out asserts its output on the expected edges.
